// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit FSM encoding, used by the ALU
// control decoder and the execute unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // LSL by zero completes in a single cycle like any other op.
  function automatic logic is_iterative_shift(input logic [3:0] ctrl, input logic [5:0] shamt);
    return (ctrl == ALU_LSL) && (shamt != 6'd0);
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative left shifter: load a value and a step count, shift by one per step.
// 'last' flags the step that produces the final shifted value on 'shifted'.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    load_count,
  output logic [WIDTH-1:0] shifted,
  output logic             last
);

  logic [WIDTH-1:0] data_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      data_reg  <= load_data;
      count_reg <= load_count;
    end else if (step) begin
      data_reg  <= data_reg << 1;
      count_reg <= count_reg - 1'b1;
    end
  end

  assign shifted = data_reg << 1;
  assign last    = (count_reg == CW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith ops, iterative LSL.
// Define ALU_FLAGS_EN to add the registered N,Z,C,V Flags output.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [5:0]       Shamt,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero
`ifdef ALU_FLAGS_EN
  , output logic [3:0]     Flags
`endif
);

  alu_state_t       state_reg;
  logic             busy_reg, done_reg, zero_reg;
  logic [WIDTH-1:0] busw_reg;
  logic [WIDTH-1:0] add_sum, sub_diff, op_result, shift_result;
  logic             shift_load, shift_step, shift_last;

  assign shift_load = (state_reg == ST_IDLE) && Start && is_iterative_shift(ALUCtrl, Shamt);
  assign shift_step = (state_reg == ST_SHIFT);

`ifdef ALU_FLAGS_EN
  logic       add_c, sub_c, op_carry, op_ovf;
  logic [3:0] flags_reg;
  assign {add_c, add_sum}  = {1'b0, BusA} + {1'b0, BusB};
  // Two's-complement subtract: carry-out is the no-borrow indication.
  assign {sub_c, sub_diff} = {1'b0, BusA} + {1'b0, ~BusB} + (WIDTH+1)'(1);

  always_comb begin
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    if (ALUCtrl == ALU_ADD) begin
      op_carry = add_c;
      op_ovf   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (add_sum[WIDTH-1] != BusA[WIDTH-1]);
    end else if (ALUCtrl == ALU_SUB) begin
      op_carry = sub_c;
      op_ovf   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sub_diff[WIDTH-1] != BusA[WIDTH-1]);
    end
  end

  assign Flags = flags_reg;
`else
  assign add_sum  = BusA + BusB;
  assign sub_diff = BusA - BusB;
`endif

  always_comb begin
    op_result = '0;
    case (ALUCtrl)
      ALU_AND:   op_result = BusA & BusB;
      ALU_ORR:   op_result = BusA | BusB;
      ALU_ADD:   op_result = add_sum;
      ALU_SUB:   op_result = sub_diff;
      ALU_PASSB: op_result = BusB;
      ALU_LSL:   op_result = BusA;  // only reached for a zero shift amount
      default:   op_result = '0;
    endcase
  end

  alu_shift_seq #(.WIDTH(WIDTH), .CW(6)) u_shift (
    .clk        (CLK),
    .srst       (Reset),
    .load       (shift_load),
    .step       (shift_step),
    .load_data  (BusA),
    .load_count (Shamt),
    .shifted    (shift_result),
    .last       (shift_last)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      busw_reg  <= '0;
      zero_reg  <= 1'b1;
`ifdef ALU_FLAGS_EN
      flags_reg <= 4'b0100;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            busy_reg <= 1'b1;
            if (shift_load) begin
              state_reg <= ST_SHIFT;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              busw_reg  <= op_result;
              zero_reg  <= (op_result == '0);
`ifdef ALU_FLAGS_EN
              flags_reg <= {op_result[WIDTH-1], (op_result == '0), op_carry, op_ovf};
`endif
            end
          end
        end
        ST_SHIFT: begin
          if (shift_last) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busw_reg  <= shift_result;
            zero_reg  <= (shift_result == '0);
`ifdef ALU_FLAGS_EN
            flags_reg <= {shift_result[WIDTH-1], (shift_result == '0), 2'b00};
`endif
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign BusW = busw_reg;
  assign Zero = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic
// checked every cycle against a latency/result reference model.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        Reset, Start;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusA, BusB;
  logic [5:0]  Shamt;
  logic        Busy, Done, Zero;
  logic [63:0] BusW;
`ifdef ALU_FLAGS_EN
  logic [3:0]  Flags;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  alu_exec_unit #(.WIDTH(64)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Start   (Start),
    .ALUCtrl (ALUCtrl),
    .BusA    (BusA),
    .BusB    (BusB),
    .Shamt   (Shamt),
    .Busy    (Busy),
    .Done    (Done),
    .BusW    (BusW),
    .Zero    (Zero)
`ifdef ALU_FLAGS_EN
    , .Flags (Flags)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_result(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                           input logic [5:0] sh);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b0011: return a << sh;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int m_latency(input logic [3:0] c, input logic [5:0] sh);
    return (c == 4'b0011) ? int'(sh) + 1 : 1;
  endfunction

  function automatic logic [3:0] m_flags(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                         input logic [5:0] sh);
    logic [63:0]        r;
    logic               cf, vf;
    logic signed [65:0] ea, eb, s, er;
    r  = m_result(c, a, b, sh);
    ea = {{2{a[63]}}, a};
    eb = {{2{b[63]}}, b};
    er = {{2{r[63]}}, r};
    cf = 1'b0;
    vf = 1'b0;
    if (c == 4'b0010) begin
      cf = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
      s  = ea + eb;
      vf = (s != er);
    end else if (c == 4'b0110) begin
      cf = (a >= b);
      s  = ea - eb;
      vf = (s != er);
    end
    return {r[63], (r == 64'd0), cf, vf};
  endfunction

  int          left = 0;  // cycles the DUT still has to be busy
  logic [63:0] pend_res, exp_busw;
  logic [3:0]  pend_flags, exp_flags;
  logic        exp_zero;

  always @(posedge CLK) begin
    if (Reset) begin
      left      <= 0;
      exp_busw  <= 64'd0;
      exp_zero  <= 1'b1;
      exp_flags <= 4'b0100;
    end else if (left == 0) begin
      if (Start) begin
        left       <= m_latency(ALUCtrl, Shamt);
        pend_res   <= m_result(ALUCtrl, BusA, BusB, Shamt);
        pend_flags <= m_flags(ALUCtrl, BusA, BusB, Shamt);
        if (m_latency(ALUCtrl, Shamt) == 1) begin
          exp_busw  <= m_result(ALUCtrl, BusA, BusB, Shamt);
          exp_zero  <= (m_result(ALUCtrl, BusA, BusB, Shamt) == 64'd0);
          exp_flags <= m_flags(ALUCtrl, BusA, BusB, Shamt);
        end
      end
    end else begin
      left <= left - 1;
      if (left == 2) begin
        exp_busw  <= pend_res;
        exp_zero  <= (pend_res == 64'd0);
        exp_flags <= pend_flags;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", Busy, left != 0);
      check("done", Done, left == 1);
      check("busw", BusW, exp_busw);
      check("zero", Zero, exp_zero);
`ifdef ALU_FLAGS_EN
      check("flags", Flags, exp_flags);
`endif
      $display("cycle t=%0t busy=%0b done=%0b busw=%h zero=%0b", $time, Busy, Done, BusW, Zero);
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh);
    ALUCtrl = c;
    BusA    = a;
    BusB    = b;
    Shamt   = sh;
    Start   = 1'b1;
  endtask

  // Counts cycles until Done; scrambles operands meanwhile so in-flight ops
  // must not depend on them. Start is re-asserted for one cycle at restart_at.
  task automatic wait_done(output int lat, input int restart_at);
    lat = 0;
    forever begin
      @(negedge CLK);
      lat++;
      Start   = (lat == restart_at);
      BusA    = {$urandom, $urandom};
      BusB    = {$urandom, $urandom};
      Shamt   = 6'($urandom);
      ALUCtrl = 4'($urandom);
      if (Done) break;
      if (lat >= 100) begin
        total++;
        bad++;
        $display("FAIL done_timeout: got no Done after %0d cycles expected Done", lat);
        break;
      end
    end
    Start = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int          lat, dcnt;
    logic [3:0]  codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b0110, 4'b0111, 4'b1111};

    Reset = 1'b1; Start = 1'b0; ALUCtrl = 4'd0; BusA = '0; BusB = '0; Shamt = '0;
    repeat (2) @(negedge CLK);
    Reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_busw", BusW, 0);
    check("rst_zero", Zero, 1);
`ifdef ALU_FLAGS_EN
    check("rst_flags", Flags, 4'b0100);
`endif

    start_op(4'b0010, 64'd5, 64'd7, 6'd0);
    wait_done(lat, 0);
    check("add_lat", lat, 1);
    check("add_busw", BusW, 64'd12);
    check("add_zero", Zero, 0);

    start_op(4'b0110, 64'h1234, 64'h1234, 6'd0);
    wait_done(lat, 0);
    check("sub_lat", lat, 1);
    check("sub_busw", BusW, 64'd0);
    check("sub_zero", Zero, 1);
`ifdef ALU_FLAGS_EN
    check("sub_flags", Flags, 4'b0110);
`endif

    start_op(4'b0011, 64'd1, 64'd0, 6'd4);
    wait_done(lat, 2);
    check("lsl_lat", lat, 5);
    check("lsl_busw", BusW, 64'd16);

    start_op(4'b1111, 64'hDEAD, 64'hBEEF, 6'd3);
    wait_done(lat, 0);
    check("ill_lat", lat, 1);
    check("ill_busw", BusW, 64'd0);
    check("ill_zero", Zero, 1);

    start_op(4'b0011, 64'd9, 64'd0, 6'd0);
    wait_done(lat, 0);
    check("lsl0_lat", lat, 1);
    check("lsl0_busw", BusW, 64'd9);

    start_op(4'b0011, 64'd3, 64'd0, 6'd20);
    dcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) dcnt++;
    end
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("abort_nodone", dcnt, 0);
    check("abort_done", Done, 0);
    check("abort_busy", Busy, 0);
    check("abort_busw", BusW, 64'd0);
    check("abort_zero", Zero, 1);

`ifdef ALU_FLAGS_EN
    start_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
    wait_done(lat, 0);
    check("ovf_busw", BusW, 64'h8000_0000_0000_0000);
    check("ovf_flags", Flags, 4'b1001);
`endif

    for (int n = 0; n < 1500; n++) begin
      @(negedge CLK);
      Reset   = ($urandom_range(0, 99) == 0);
      Start   = ($urandom_range(0, 2) == 0);
      ALUCtrl = ($urandom_range(0, 7) == 7) ? 4'($urandom) : codes[$urandom_range(0, 7)];
      BusA    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      BusB    = ($urandom_range(0, 3) == 0) ? BusA : {$urandom, $urandom};
      Shamt   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
    end
    Reset = 1'b0;
    Start = 1'b0;
    repeat (70) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
